// File: rtl/data_mem_sequencer.sv
// Arbitrates CPU and debug access to a byte-wide data RAM, splitting B/H/W
// accesses into byte beats and returning RISC-V extended load data.
module data_mem_sequencer #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_we,
   input  logic [ADDRESS_WIDTH-1:0]  cpu_addr,
   input  logic [2:0]                cpu_funct3,
   input  logic [DATA_WIDTH-1:0]     cpu_wdata,
   output logic                      cpu_rsp_valid,
   output logic                      cpu_rsp_err,
   output logic [DATA_WIDTH-1:0]     cpu_rdata,
   input  logic                      dbg_req_valid,
   output logic                      dbg_req_ready,
   input  logic                      dbg_we,
   input  logic [ADDRESS_WIDTH-1:0]  dbg_addr,
   input  logic [2:0]                dbg_funct3,
   input  logic [DATA_WIDTH-1:0]     dbg_wdata,
   output logic                      dbg_rsp_valid,
   output logic                      dbg_rsp_err,
   output logic [DATA_WIDTH-1:0]     dbg_rdata,
   output logic                      ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]                ram_wd,
   input  logic [7:0]                ram_rd,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t                    state, state_nxt;
   logic                      owner_dbg_q;
   logic                      we_q;
   logic                      err_q;
   logic [RAM_ADDR_WIDTH-1:0] base_q;
   logic [2:0]                funct3_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH-1:0]     rbuf_q;
   logic [1:0]                beat_q;
   logic [1:0]                last_beat_q;

   logic                      pick_dbg;
   logic                      accept;
   logic                      sel_we;
   logic                      sel_legal;
   logic [RAM_ADDR_WIDTH-1:0] sel_addr;
   logic [2:0]                sel_funct3;
   logic [DATA_WIDTH-1:0]     sel_wdata;
   logic [1:0]                sel_last_beat;
   logic [DATA_WIDTH-1:0]     load_ext;
   logic                      addr_hi_unused;

   assign addr_hi_unused = ^{cpu_addr[ADDRESS_WIDTH-1:RAM_ADDR_WIDTH],
                             dbg_addr[ADDRESS_WIDTH-1:RAM_ADDR_WIDTH]};

   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
   endfunction

   // owner_dbg_q doubles as the round-robin pointer: it names the last grant.
   always_comb begin
      if (cpu_req_valid && dbg_req_valid)
         pick_dbg = (FIXED_PRIORITY == 0) && !owner_dbg_q;
      else
         pick_dbg = dbg_req_valid;
      accept     = !rst && (state == IDLE) && (cpu_req_valid || dbg_req_valid);
      sel_we     = pick_dbg ? dbg_we : cpu_we;
      sel_addr   = pick_dbg ? dbg_addr[RAM_ADDR_WIDTH-1:0] : cpu_addr[RAM_ADDR_WIDTH-1:0];
      sel_funct3 = pick_dbg ? dbg_funct3 : cpu_funct3;
      sel_wdata  = pick_dbg ? dbg_wdata : cpu_wdata;
      sel_legal  = funct3_legal(sel_we, sel_funct3);
      case (sel_funct3[1:0])
         2'b00:   sel_last_beat = 2'd0;
         2'b01:   sel_last_beat = 2'd1;
         default: sel_last_beat = 2'd3;
      endcase
   end

   always_comb begin
      load_ext = '0;
      case (funct3_q)
         3'b000:  load_ext = {{24{rbuf_q[7]}}, rbuf_q[7:0]};
         3'b001:  load_ext = {{16{rbuf_q[15]}}, rbuf_q[15:0]};
         3'b010:  load_ext = rbuf_q;
         3'b100:  load_ext = {24'b0, rbuf_q[7:0]};
         3'b101:  load_ext = {16'b0, rbuf_q[15:0]};
         default: load_ext = '0;
      endcase
      if (we_q || err_q)
         load_ext = '0;
   end

   // Outputs are forced low while rst is high so an aborted transfer issues no further beat.
   always_comb begin
      state_nxt     = state;
      cpu_req_ready = 1'b0;
      dbg_req_ready = 1'b0;
      cpu_rsp_valid = 1'b0;
      cpu_rsp_err   = 1'b0;
      cpu_rdata     = '0;
      dbg_rsp_valid = 1'b0;
      dbg_rsp_err   = 1'b0;
      dbg_rdata     = '0;
      ram_we        = 1'b0;
      ram_addr      = '0;
      ram_wd        = '0;
      busy          = 1'b0;
      if (!rst) begin
         busy = (state != IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  cpu_req_ready = !pick_dbg;
                  dbg_req_ready = pick_dbg;
                  state_nxt     = sel_legal ? XFER : RESP;
               end
            end
            XFER: begin
               ram_we   = we_q;
               ram_addr = base_q + RAM_ADDR_WIDTH'(beat_q);
               ram_wd   = we_q ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
               if (beat_q == last_beat_q)
                  state_nxt = RESP;
            end
            RESP: begin
               if (owner_dbg_q) begin
                  dbg_rsp_valid = 1'b1;
                  dbg_rsp_err   = err_q;
                  dbg_rdata     = load_ext;
               end else begin
                  cpu_rsp_valid = 1'b1;
                  cpu_rsp_err   = err_q;
                  cpu_rdata     = load_ext;
               end
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_dbg_q <= 1'b1;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         base_q      <= '0;
         funct3_q    <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         beat_q      <= '0;
         last_beat_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner_dbg_q <= pick_dbg;
            we_q        <= sel_we;
            err_q       <= !sel_legal;
            base_q      <= sel_addr;
            funct3_q    <= sel_funct3;
            wdata_q     <= sel_wdata;
            last_beat_q <= sel_last_beat;
            beat_q      <= '0;
            rbuf_q      <= '0;
         end else if (state == XFER) begin
            if (!we_q)
               rbuf_q[{beat_q, 3'b000} +: 8] <= ram_rd;
            beat_q <= beat_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Bench for data_mem_sequencer: a round-robin and a fixed-priority instance, each
// compared every cycle with a transaction-level model, plus literal directed cases.
module tb_data_mem_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, init;
   logic        cv [2], cr [2], cwe [2], crv [2], cre [2];
   logic [31:0] ca [2], cwd [2], crd [2];
   logic [2:0]  cf [2];
   logic        dv [2], dr [2], dwe [2], drv [2], dre [2];
   logic [31:0] da [2], dwd [2], drd [2];
   logic [2:0]  df [2];
   logic        rwe [2], bsy [2];
   logic [7:0]  radr [2], rwd [2], rrd [2];
   logic [7:0]  ram [2][256];

   int checks = 0;
   int failures = 0;

   data_mem_sequencer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(8),
                        .FIXED_PRIORITY(0)) u_rr (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cv[0]), .cpu_req_ready(cr[0]), .cpu_we(cwe[0]), .cpu_addr(ca[0]),
      .cpu_funct3(cf[0]), .cpu_wdata(cwd[0]), .cpu_rsp_valid(crv[0]), .cpu_rsp_err(cre[0]),
      .cpu_rdata(crd[0]),
      .dbg_req_valid(dv[0]), .dbg_req_ready(dr[0]), .dbg_we(dwe[0]), .dbg_addr(da[0]),
      .dbg_funct3(df[0]), .dbg_wdata(dwd[0]), .dbg_rsp_valid(drv[0]), .dbg_rsp_err(dre[0]),
      .dbg_rdata(drd[0]),
      .ram_we(rwe[0]), .ram_addr(radr[0]), .ram_wd(rwd[0]), .ram_rd(rrd[0]), .busy(bsy[0]));

   data_mem_sequencer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(8),
                        .FIXED_PRIORITY(1)) u_fp (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cv[1]), .cpu_req_ready(cr[1]), .cpu_we(cwe[1]), .cpu_addr(ca[1]),
      .cpu_funct3(cf[1]), .cpu_wdata(cwd[1]), .cpu_rsp_valid(crv[1]), .cpu_rsp_err(cre[1]),
      .cpu_rdata(crd[1]),
      .dbg_req_valid(dv[1]), .dbg_req_ready(dr[1]), .dbg_we(dwe[1]), .dbg_addr(da[1]),
      .dbg_funct3(df[1]), .dbg_wdata(dwd[1]), .dbg_rsp_valid(drv[1]), .dbg_rsp_err(dre[1]),
      .dbg_rdata(drd[1]),
      .ram_we(rwe[1]), .ram_addr(radr[1]), .ram_wd(rwd[1]), .ram_rd(rrd[1]), .busy(bsy[1]));

   function automatic logic [7:0] pat(input int a);
      case (a)
         16:      return 8'h11;
         17:      return 8'h22;
         18:      return 8'h33;
         19:      return 8'h84;
         default: return 8'(a * 7 + 3);
      endcase
   endfunction

   always @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (init) begin
            for (int a = 0; a < 256; a++) ram[i][a] <= pat(a);
         end else if (rwe[i]) begin
            ram[i][radr[i]] <= rwd[i];
         end

   assign rrd[0] = ram[0][radr[0]];
   assign rrd[1] = ram[1][radr[1]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   // Transaction-level reference: one pending access per instance, a beat schedule
   // derived from its size, and a shadow memory.
   logic [7:0]  mem_m [2][256];
   bit          m_act [2], m_dbg [2], m_we [2], m_err [2], m_lastdbg [2];
   int          m_k [2], m_n [2];
   logic [7:0]  m_base [2];
   logic [31:0] m_wd [2], m_rv [2];

   task automatic model_step(input int i);
      logic        g_c, g_d, lwe, legal, load_beat, e_busy;
      logic [2:0]  f3;
      logic [7:0]  b, ba, bd;
      logic [31:0] w, wd;
      logic [1:0]  e_rdy;
      logic [16:0] e_ram;
      logic [33:0] e_c, e_d;
      int          v, j;
      e_rdy = '0; e_ram = '0; e_c = '0; e_d = '0; e_busy = 1'b0; load_beat = 1'b0;
      if (rst) begin
         m_act[i] = 1'b0;
         m_lastdbg[i] = 1'b1;
      end else if (!m_act[i]) begin
         g_c = cv[i] && (!dv[i] || (i == 1) || m_lastdbg[i]);
         g_d = dv[i] && !g_c;
         e_rdy = {g_c, g_d};
         if (g_c || g_d) begin
            lwe = g_d ? dwe[i] : cwe[i];
            b   = g_d ? da[i][7:0] : ca[i][7:0];
            f3  = g_d ? df[i] : cf[i];
            wd  = g_d ? dwd[i] : cwd[i];
            legal = lwe ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
            m_act[i] = 1'b1; m_k[i] = 1; m_dbg[i] = g_d; m_lastdbg[i] = g_d;
            m_we[i] = lwe; m_err[i] = !legal; m_base[i] = b; m_wd[i] = wd;
            m_n[i] = legal ? (1 << f3[1:0]) : 0;
            for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_m[i][8'(int'(b) + k)];
            case (f3)
               3'd0: begin v = int'(w[7:0]);  if (v > 127)   v -= 256;   m_rv[i] = 32'(v); end
               3'd1: begin v = int'(w[15:0]); if (v > 32767) v -= 65536; m_rv[i] = 32'(v); end
               3'd4: m_rv[i] = 32'(w[7:0]);
               3'd5: m_rv[i] = 32'(w[15:0]);
               default: m_rv[i] = w;
            endcase
            if (lwe || !legal) m_rv[i] = '0;
         end
      end else begin
         e_busy = 1'b1;
         if (m_k[i] <= m_n[i]) begin
            j  = m_k[i] - 1;
            ba = 8'(int'(m_base[i]) + j);
            bd = 8'(m_wd[i] >> (8 * j));
            load_beat = !m_we[i];
            e_ram = {m_we[i], ba, m_we[i] ? bd : 8'h00};
            if (m_we[i]) mem_m[i][ba] = bd;
         end else if (m_dbg[i]) begin
            e_d = {1'b1, m_err[i], m_rv[i]};
         end else begin
            e_c = {1'b1, m_err[i], m_rv[i]};
         end
         m_k[i]++;
         if (m_k[i] > m_n[i] + 1) m_act[i] = 1'b0;
      end
      chk($sformatf("ready%0d", i), 64'({cr[i], dr[i]}), 64'(e_rdy));
      chk($sformatf("ram%0d", i), 64'({rwe[i], radr[i], load_beat ? 8'h00 : rwd[i]}), 64'(e_ram));
      chk($sformatf("cpu_rsp%0d", i), 64'({crv[i], cre[i], crd[i]}), 64'(e_c));
      chk($sformatf("dbg_rsp%0d", i), 64'({drv[i], dre[i], drd[i]}), 64'(e_d));
      chk($sformatf("busy%0d", i), 64'(bsy[i]), 64'(e_busy));
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 256; a++) mem_m[i][a] = pat(a);
         m_act[i] = 1'b0;
         m_lastdbg[i] = 1'b1;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   task automatic dir_req(input int i, input bit d, input bit we, input logic [31:0] a,
                          input logic [2:0] f, input logic [31:0] wd, input logic [31:0] er,
                          input bit ee, input int elat, input string nm);
      int t;
      bit got;
      @(posedge clk); #1;
      if (d) begin dv[i] = 1; dwe[i] = we; da[i] = a; df[i] = f; dwd[i] = wd; end
      else   begin cv[i] = 1; cwe[i] = we; ca[i] = a; cf[i] = f; cwd[i] = wd; end
      t = 0; got = 0;
      while (!got && t < 20) begin @(negedge clk); got = d ? dr[i] : cr[i]; t++; end
      chk({nm, "_acc"}, 64'(got), 64'(1));
      @(posedge clk); #1;
      if (d) begin dv[i] = 0; dwe[i] = ~we; da[i] = $urandom; df[i] = 3'($urandom); dwd[i] = $urandom; end
      else   begin cv[i] = 0; cwe[i] = ~we; ca[i] = $urandom; cf[i] = 3'($urandom); cwd[i] = $urandom; end
      t = 0; got = 0;
      while (!got && t < 20) begin @(negedge clk); t++; got = d ? drv[i] : crv[i]; end
      chk({nm, "_lat"}, 64'(t), 64'(elat));
      chk({nm, "_data"}, 64'(d ? drd[i] : crd[i]), 64'(er));
      chk({nm, "_err"}, 64'(d ? dre[i] : cre[i]), 64'(ee));
   endtask

   bit         tc [2], td [2];
   int         nc [2], nd [2], ng [2];
   logic [5:0] ord [2];

   initial begin
      int t;
      rst = 1; init = 1;
      for (int i = 0; i < 2; i++) begin
         cv[i] = 0; cwe[i] = 0; ca[i] = '0; cf[i] = '0; cwd[i] = '0;
         dv[i] = 0; dwe[i] = 0; da[i] = '0; df[i] = '0; dwd[i] = '0;
      end
      @(posedge clk); #1; init = 0;
      @(posedge clk); #1; rst = 0;

      dir_req(0, 0, 0, 32'h0000_0010, 3'b010, 32'h0, 32'h8433_2211, 0, 5, "lw_10");
      dir_req(0, 0, 0, 32'h0000_0013, 3'b000, 32'h0, 32'hFFFF_FF84, 0, 2, "lb_13");
      dir_req(0, 0, 0, 32'h0000_0013, 3'b100, 32'h0, 32'h0000_0084, 0, 2, "lbu_13");
      dir_req(0, 0, 0, 32'h0000_0012, 3'b001, 32'h0, 32'hFFFF_8433, 0, 3, "lh_12");
      dir_req(0, 0, 0, 32'h0000_0012, 3'b101, 32'h0, 32'h0000_8433, 0, 3, "lhu_12");
      dir_req(0, 0, 1, 32'h1234_56FE, 3'b010, 32'hAABB_CCDD, 32'h0, 0, 5, "sw_fe");
      chk("wrap_mem", 64'({ram[0][254], ram[0][255], ram[0][0], ram[0][1]}), 64'(32'hDDCC_BBAA));
      dir_req(0, 0, 0, 32'h0000_00FE, 3'b010, 32'h0, 32'hAABB_CCDD, 0, 5, "lw_fe");
      dir_req(0, 1, 0, 32'h0000_0040, 3'b011, 32'h0, 32'h0, 1, 1, "dbg_ld011");
      dir_req(0, 1, 1, 32'h0000_0040, 3'b100, 32'hFFFF_FFFF, 32'h0, 1, 1, "dbg_st100");

      // store aborted by reset during its third beat, then a load right after reset
      @(posedge clk); #1; cv[0] = 1; cwe[0] = 1; ca[0] = 32'h20; cf[0] = 3'b010; cwd[0] = 32'h4433_2211;
      @(negedge clk); chk("abort_acc", 64'(cr[0]), 64'(1));
      @(posedge clk); #1; cv[0] = 0; cwd[0] = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0; cv[0] = 1; cwe[0] = 0; ca[0] = 32'h20; cf[0] = 3'b010;
      @(negedge clk); chk("post_rst_ready", 64'(cr[0]), 64'(1));
      chk("abort_mem", 64'({ram[0][32], ram[0][33], ram[0][34], ram[0][35]}), 64'(32'h1122_F1F8));
      @(posedge clk); #1; cv[0] = 0;
      t = 0;
      while (!crv[0] && t < 20) begin @(negedge clk); t++; end
      chk("abort_lw_lat", 64'(t), 64'(5));
      chk("abort_lw_data", 64'(crd[0]), 64'(32'hF8F1_2211));

      // arbitration: both requesters hold valid for three byte stores each
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0;
      for (int i = 0; i < 2; i++) begin
         nc[i] = 0; nd[i] = 0; ng[i] = 0; ord[i] = '0;
         cv[i] = 1; cwe[i] = 1; cf[i] = 3'b000; ca[i] = 32'h80; cwd[i] = $urandom;
         dv[i] = 1; dwe[i] = 1; df[i] = 3'b000; da[i] = 32'h90; dwd[i] = $urandom;
      end
      for (int cyc = 0; cyc < 200 && (ng[0] < 6 || ng[1] < 6); cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            tc[i] = cv[i] && cr[i];
            td[i] = dv[i] && dr[i];
            if (tc[i]) begin ord[i] = {ord[i][4:0], 1'b0}; ng[i]++; end
            if (td[i]) begin ord[i] = {ord[i][4:0], 1'b1}; ng[i]++; end
         end
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (tc[i]) begin nc[i]++; cv[i] = (nc[i] < 3); ca[i] = 32'(32'h80 + nc[i]); cwd[i] = $urandom; end
            if (td[i]) begin nd[i]++; dv[i] = (nd[i] < 3); da[i] = 32'(32'h90 + nd[i]); dwd[i] = $urandom; end
         end
      end
      chk("arb_rr_order", 64'(ord[0]), 64'(6'b010101));
      chk("arb_fp_order", 64'(ord[1]), 64'(6'b000111));

      // randomized traffic with occasional resets
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            tc[i] = cv[i] && cr[i];
            td[i] = dv[i] && dr[i];
         end
         @(posedge clk); #1;
         rst = ($urandom_range(0, 249) == 0);
         for (int i = 0; i < 2; i++) begin
            if (!cv[i] || tc[i]) begin
               cv[i] = ($urandom_range(0, 3) != 0); cwe[i] = 1'($urandom_range(0, 1));
               ca[i] = $urandom; cf[i] = 3'($urandom_range(0, 7)); cwd[i] = $urandom;
            end
            if (!dv[i] || td[i]) begin
               dv[i] = ($urandom_range(0, 3) != 0); dwe[i] = 1'($urandom_range(0, 1));
               da[i] = $urandom; df[i] = 3'($urandom_range(0, 7)); dwd[i] = $urandom;
            end
         end
      end
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < 2; i++) begin cv[i] = 0; dv[i] = 0; end
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         int bad;
         bad = 0;
         for (int a = 0; a < 256; a++) if (ram[i][a] !== mem_m[i][a]) bad++;
         chk($sformatf("mem_final%0d", i), 64'(bad), 64'(0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
